// File: rtl/dispatch_pipe.sv
// dispatch_pipe: single-entry staging register between the decode fifo and the
// per-type issue channels. Serial instructions (fence, csr) wait for an empty
// ROB, dispatch alone, and then block further dispatch until the ROB drains.
// Optional feature macro: DISPATCH_PERF_EN adds perf_disp_cnt / perf_stall_cnt.
//
// state      | meaning
// RUN        | normal dispatch; a staged serial entry moves to WAIT_EMPTY
// WAIT_EMPTY | serial entry staged, fires only once the ROB is empty
// WAIT_DONE  | serial entry issued; no fire/pop until the ROB is empty again
module dispatch_pipe #(
  parameter int DW = 64,
  parameter int CH = 7
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          instrFifo_empty,
  output logic          instrFifo_pop,
  input  logic [DW-1:0] decode_info,
  input  logic [CH-1:0] decode_tgt,
  input  logic          decode_serial,
  input  logic          rd0_runOut,
  input  logic          reOrder_fifo_full,
  input  logic          reOrder_empty,
  input  logic          flush,
  input  logic [CH-1:0] ch_full,
  output logic [CH-1:0] ch_push,
  output logic [DW-1:0] dispat_info,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]   perf_disp_cnt,
  output logic [31:0]   perf_stall_cnt,
`endif
  output logic          reOrder_fifo_push,
  output logic          rd0_raw_vaild
);

  typedef enum logic [1:0] {RUN, WAIT_EMPTY, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic          stage_valid;
  logic [DW-1:0] stage_info;
  logic [CH-1:0] stage_tgt;
  logic          stage_serial;
  logic [CH-1:0] sel_oh;
  logic          permit, fire, drop, pop;

  // One-hot of the lowest set target bit; multi-hot targets go to the lowest channel.
  always_comb begin
    sel_oh = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (stage_tgt[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Dispatch permission, fire/drop/pop decisions and next state.
  always_comb begin
    permit    = 1'b0;
    state_nxt = state;
    case (state)
      RUN:        permit = ~stage_serial;
      WAIT_EMPTY: permit = reOrder_empty;
      WAIT_DONE:  permit = 1'b0;
      default:    permit = 1'b0;
    endcase

    // A zero target is an unrealized instruction: it never fires, it is dropped.
    fire = RSTn & stage_valid & (|sel_oh) & permit & ~rd0_runOut &
           ~reOrder_fifo_full & ~(|(ch_full & sel_oh)) & ~flush;
    drop = RSTn & stage_valid & ~(|stage_tgt) & ~flush;
    pop  = RSTn & ~instrFifo_empty & ~flush & (state != WAIT_DONE) &
           (~stage_valid | fire | drop);

    case (state)
      RUN:        if (stage_valid && stage_serial && (|stage_tgt)) state_nxt = WAIT_EMPTY;
      WAIT_EMPTY: if (fire) state_nxt = WAIT_DONE;
      WAIT_DONE:  if (reOrder_empty) state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
    if (flush) state_nxt = RUN;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= RUN;
    else       state <= state_nxt;
  end

  // Staging register: flush empties it, pop reloads it, fire/drop retire it.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      stage_valid  <= 1'b0;
      stage_info   <= '0;
      stage_tgt    <= '0;
      stage_serial <= 1'b0;
    end else if (flush) begin
      stage_valid  <= 1'b0;
    end else if (pop) begin
      stage_valid  <= 1'b1;
      stage_info   <= decode_info;
      stage_tgt    <= decode_tgt;
      stage_serial <= decode_serial;
    end else if (fire || drop) begin
      stage_valid  <= 1'b0;
    end
  end

`ifdef DISPATCH_PERF_EN
  // Dispatch and stall event counters, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      perf_disp_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fire) perf_disp_cnt <= perf_disp_cnt + 32'd1;
      if (stage_valid && !fire && !drop) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign instrFifo_pop     = pop;
  assign ch_push           = fire ? sel_oh : '0;
  assign reOrder_fifo_push = fire;
  assign rd0_raw_vaild     = fire;
  // Gated so the staged payload reads zero while reset is held.
  assign dispat_info       = RSTn ? stage_info : '0;

endmodule

// File: tb/tb_dispatch_pipe.sv
// Bench for dispatch_pipe: directed scenarios followed by random traffic, all
// checked against a queue-based model of the staging/serialization rules.
module tb_dispatch_pipe;
  localparam int DW = 64;
  localparam int CH = 7;

  typedef struct packed {
    logic [DW-1:0] info;
    logic [CH-1:0] tgt;
    logic          serial;
  } ent_t;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          instrFifo_empty;
  logic          instrFifo_pop;
  logic [DW-1:0] decode_info;
  logic [CH-1:0] decode_tgt;
  logic          decode_serial;
  logic          rd0_runOut;
  logic          reOrder_fifo_full;
  logic          reOrder_empty;
  logic          flush;
  logic [CH-1:0] ch_full;
  logic [CH-1:0] ch_push;
  logic [DW-1:0] dispat_info;
  logic          reOrder_fifo_push;
  logic          rd0_raw_vaild;
`ifdef DISPATCH_PERF_EN
  logic [31:0]   perf_disp_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  always #5 CLK = ~CLK;

  dispatch_pipe #(.DW(DW), .CH(CH)) dut (
    .CLK               (CLK),
    .RSTn              (RSTn),
    .instrFifo_empty   (instrFifo_empty),
    .instrFifo_pop     (instrFifo_pop),
    .decode_info       (decode_info),
    .decode_tgt        (decode_tgt),
    .decode_serial     (decode_serial),
    .rd0_runOut        (rd0_runOut),
    .reOrder_fifo_full (reOrder_fifo_full),
    .reOrder_empty     (reOrder_empty),
    .flush             (flush),
    .ch_full           (ch_full),
    .ch_push           (ch_push),
    .dispat_info       (dispat_info),
`ifdef DISPATCH_PERF_EN
    .perf_disp_cnt     (perf_disp_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
`endif
    .reOrder_fifo_push (reOrder_fifo_push),
    .rd0_raw_vaild     (rd0_raw_vaild)
  );

  // src_q: decode fifo contents; exp_q: entry the model believes is staged.
  ent_t src_q[$];
  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_fire = 0;
  int   n_stall = 0;
  logic hold = 1'b0;   // serial entry issued, waiting for ROB to drain
  logic armed = 1'b0;  // staged serial entry has spent its one cycle in RUN

  logic [CH-1:0] obs_push;
  logic          obs_pop, obs_rob, obs_raw;
  logic [DW-1:0] obs_info;
  logic [DW-1:0] b_info;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] low_oh(input logic [CH-1:0] t);
    for (int i = 0; i < CH; i++) if (t[i]) return CH'(1) << i;
    return '0;
  endfunction

  function automatic logic [CH-1:0] rand_tgt();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return CH'($urandom);
    return CH'(1) << $urandom_range(0, CH - 1);
  endfunction

  task automatic mk(input logic [CH-1:0] t, input logic s);
    ent_t e;
    e.info   = {$urandom, $urandom};
    e.tgt    = t;
    e.serial = s;
    src_q.push_back(e);
  endtask

  task automatic quiet();
    rd0_runOut        = 1'b0;
    reOrder_fifo_full = 1'b0;
    reOrder_empty     = 1'b1;
    flush             = 1'b0;
    ch_full           = '0;
  endtask

  // One clock: present fifo head, check outputs against the model, advance model.
  task automatic tick();
    ent_t          h;
    logic          head_v, e_drop, e_pop, was_hold;
    logic [CH-1:0] e_push;
    instrFifo_empty = (src_q.size() == 0);
    if (src_q.size() != 0) begin
      decode_info   = src_q[0].info;
      decode_tgt    = src_q[0].tgt;
      decode_serial = src_q[0].serial;
    end else begin
      decode_info   = '0;
      decode_tgt    = '0;
      decode_serial = 1'b0;
    end
    #1;
    obs_push = ch_push;
    obs_pop  = instrFifo_pop;
    obs_rob  = reOrder_fifo_push;
    obs_raw  = rd0_raw_vaild;
    obs_info = dispat_info;
    head_v   = (exp_q.size() != 0);
    h        = '0;
    if (head_v) h = exp_q[0];
    e_push = '0;
    e_drop = 1'b0;
    e_pop  = 1'b0;
    if (!RSTn) begin
      chk("rst_info", 64'(obs_info), 64'(0));
    end else begin
      e_drop = head_v && (h.tgt == '0) && !flush;
      if (head_v && (h.tgt != '0) && !flush && !rd0_runOut && !reOrder_fifo_full &&
          !hold && ((ch_full & low_oh(h.tgt)) == '0) &&
          (!h.serial || (armed && reOrder_empty)))
        e_push = low_oh(h.tgt);
      e_pop = !instrFifo_empty && !flush && !hold && (!head_v || (e_push != '0) || e_drop);
      if (head_v) chk("info", 64'(obs_info), 64'(h.info));
    end
    chk("push", 64'(obs_push), 64'(e_push));
    chk("pop", 64'(obs_pop), 64'(e_pop));
    chk("rob_push", 64'(obs_rob), 64'(|e_push));
    chk("raw_vld", 64'(obs_raw), 64'(|e_push));
    @(posedge CLK);
    if (!RSTn) begin
      exp_q.delete();
      hold = 1'b0; armed = 1'b0; n_fire = 0; n_stall = 0;
    end else begin
      if (head_v && (e_push == '0) && !e_drop) n_stall++;
      if (e_push != '0) n_fire++;
      if (flush) begin
        exp_q.delete();
        hold = 1'b0; armed = 1'b0;
      end else begin
        was_hold = hold;
        if ((e_push != '0) && h.serial) hold = 1'b1;
        else if (hold && reOrder_empty) hold = 1'b0;
        if ((e_push != '0) || e_drop) begin
          void'(exp_q.pop_front());
          armed = 1'b0;
        end else if (head_v && h.serial && !was_hold) begin
          armed = 1'b1;
        end
        if (e_pop) exp_q.push_back(src_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    quiet();
    while ((src_q.size() != 0 || exp_q.size() != 0 || hold) && n < 40) begin
      tick();
      n++;
    end
    chk("drain", 64'(src_q.size() + exp_q.size()), 64'(0));
  endtask

  initial begin
    // Reset with permissive inputs and a non-empty fifo: all outputs must stay 0.
    RSTn = 1'b0;
    quiet();
    mk(7'b0000001, 1'b0);
    tick();
    tick();
    src_q.delete();
    RSTn = 1'b1;
    tick();

    // Stream of four adder ops.
    quiet();
    for (int i = 0; i < 4; i++) mk(7'b0000001, 1'b0);
    tick();
    chk("a_first_push", 64'(obs_push), 64'(0));
    chk("a_first_pop", 64'(obs_pop), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_stream", 64'(obs_push), 64'(7'b0000001));
    end
    tick();
    chk("a_after", 64'(obs_push), 64'(0));
    drain();

    // lsu op stalled by its full channel.
    quiet();
    ch_full = 7'b0100000;
    mk(7'b0100000, 1'b0);
    mk(7'b0000001, 1'b0);
    b_info = src_q[0].info;
    tick();
    chk("b_load_pop", 64'(obs_pop), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_stall_push", 64'(obs_push), 64'(0));
      chk("b_stall_pop", 64'(obs_pop), 64'(0));
      chk("b_stall_info", 64'(obs_info), 64'(b_info));
    end
    ch_full = '0;
    tick();
    chk("b_release", 64'(obs_push), 64'(7'b0100000));
    drain();

    // Serial csr op waiting on ROB empty, then WAIT_DONE.
    quiet();
    reOrder_empty = 1'b0;
    mk(7'b1000000, 1'b1);
    mk(7'b0000001, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c_wait", 64'(obs_push), 64'(0));
    end
    reOrder_empty = 1'b1;
    tick();
    chk("c_fire", 64'(obs_push), 64'(7'b1000000));
    reOrder_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("c_done_push", 64'(obs_push), 64'(0));
      chk("c_done_pop", 64'(obs_pop), 64'(0));
    end
    reOrder_empty = 1'b1;
    tick();
    chk("c_exit_cycle", 64'(obs_push), 64'(0));
    tick();
    chk("c_next", 64'(obs_push), 64'(7'b0000001));
    drain();

    // Unrealized (tgt zero) entry is dropped while the next one loads.
    quiet();
    mk(7'b0000000, 1'b0);
    mk(7'b0000001, 1'b0);
    tick();
    tick();
    chk("d_drop_push", 64'(obs_push), 64'(0));
    chk("d_drop_rob", 64'(obs_rob), 64'(0));
    chk("d_drop_pop", 64'(obs_pop), 64'(1));
    tick();
    chk("d_next", 64'(obs_push), 64'(7'b0000001));
    drain();

    // Flush in WAIT_EMPTY: stage cleared, back to RUN.
    quiet();
    reOrder_empty = 1'b0;
    mk(7'b1000000, 1'b1);
    tick();
    tick();
    mk(7'b0000001, 1'b0);
    flush = 1'b1;
    tick();
    chk("e_flush_push", 64'(obs_push), 64'(0));
    chk("e_flush_pop", 64'(obs_pop), 64'(0));
    flush = 1'b0;
    tick();
    chk("e_empty_push", 64'(obs_push), 64'(0));
    chk("e_empty_pop", 64'(obs_pop), 64'(1));
    tick();
    chk("e_run_push", 64'(obs_push), 64'(7'b0000001));
    drain();

    // Multi-hot target: lowest channel only, higher full channels ignored.
    quiet();
    ch_full = 7'b0110000;
    mk(7'b0110100, 1'b0);
    tick();
    tick();
    chk("f_multihot", 64'(obs_push), 64'(7'b0000100));
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (src_q.size() < 3 && $urandom_range(0, 99) < 60)
        mk(rand_tgt(), $urandom_range(0, 99) < 10);
      rd0_runOut        = $urandom_range(0, 99) < 10;
      reOrder_fifo_full = $urandom_range(0, 99) < 10;
      reOrder_empty     = $urandom_range(0, 99) < 50;
      flush             = $urandom_range(0, 99) < 3;
      for (int i = 0; i < CH; i++) ch_full[i] = $urandom_range(0, 99) < 15;
      tick();
    end
    drain();

`ifdef DISPATCH_PERF_EN
    chk("perf_disp", 64'(perf_disp_cnt), 64'(n_fire));
    chk("perf_stall", 64'(perf_stall_cnt), 64'(n_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
